// File: rtl/mdu_unit.sv
// Multiply/divide unit with private HI/LO registers; MULT/MULTU/DIV/DIVU/MTHI/MTLO.
// Latency: MTHI/MTLO 1 cycle; mul MUL_CYCLES, div DIV_CYCLES of busy, HI/LO land as busy falls.
// No queueing: ops presented while busy or with req (flush) are dropped; the hazard unit stalls on busy.
module mdu_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        req,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  // Counter reload values: the final RUN cycle is the one with counter==0.
  localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [3:0]  counter;
  logic [31:0] pending_hi;
  logic [31:0] pending_lo;
  logic        pending_wr;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic [31:0] rt_mag_safe;
  logic [31:0] rt_safe;
  logic [31:0] mag_q;
  logic [31:0] mag_r;
  logic [31:0] div_sq;
  logic [31:0] div_sr;
  logic [31:0] div_uq;
  logic [31:0] div_ur;

  // Results are computed from the operands at the accept edge and parked in pending_*.
  // Signed division runs on magnitudes so truncation toward zero and the
  // dividend-signed remainder fall out directly; 0x80000000/-1 wraps to 0x80000000.
  // A zero divisor is swapped for 1 only to keep the dividers defined; that result is never written.
  always_comb begin
    prod_s      = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
    prod_u      = {32'd0, rs_data} * {32'd0, rt_data};
    rs_mag      = rs_data[31] ? -rs_data : rs_data;
    rt_mag      = rt_data[31] ? -rt_data : rt_data;
    rt_mag_safe = (rt_mag == 32'd0) ? 32'd1 : rt_mag;
    rt_safe     = (rt_data == 32'd0) ? 32'd1 : rt_data;
    mag_q       = rs_mag / rt_mag_safe;
    mag_r       = rs_mag % rt_mag_safe;
    div_sq      = (rs_data[31] ^ rt_data[31]) ? -mag_q : mag_q;
    div_sr      = rs_data[31] ? -mag_r : mag_r;
    div_uq      = rs_data / rt_safe;
    div_ur      = rs_data % rt_safe;
  end

  // Control FSM plus HI/LO: accept in IDLE without flush, count down in RUN, commit on counter==0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      counter    <= 4'd0;
      busy       <= 1'b0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      pending_hi <= 32'd0;
      pending_lo <= 32'd0;
      pending_wr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!req) begin
            case (mdu_op)
              OP_MULT: begin
                pending_hi <= prod_s[63:32];
                pending_lo <= prod_s[31:0];
                pending_wr <= 1'b1;
                counter    <= MUL_CNT;
                state      <= RUN;
                busy       <= 1'b1;
              end
              OP_MULTU: begin
                pending_hi <= prod_u[63:32];
                pending_lo <= prod_u[31:0];
                pending_wr <= 1'b1;
                counter    <= MUL_CNT;
                state      <= RUN;
                busy       <= 1'b1;
              end
              OP_DIV: begin
                pending_hi <= div_sr;
                pending_lo <= div_sq;
                pending_wr <= (rt_data != 32'd0);
                counter    <= DIV_CNT;
                state      <= RUN;
                busy       <= 1'b1;
              end
              OP_DIVU: begin
                pending_hi <= div_ur;
                pending_lo <= div_uq;
                pending_wr <= (rt_data != 32'd0);
                counter    <= DIV_CNT;
                state      <= RUN;
                busy       <= 1'b1;
              end
              OP_MTHI: hi <= rs_data;
              OP_MTLO: lo <= rs_data;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (counter != 4'd0) begin
            counter <= counter - 4'd1;
          end else begin
            if (pending_wr) begin
              hi <= pending_hi;
              lo <= pending_lo;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboarded bench for mdu_unit: the driver predicts HI/LO/busy after every edge and queues it.
// Latency: the monitor compares each queued prediction on the falling edge after its rising edge.
// Reference model works in edge numbers and plain integer arithmetic.
module tb_mdu_unit;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  mdu_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        req;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  mdu_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk    (clk),
    .reset  (reset),
    .mdu_op (mdu_op),
    .rs_data(rs_data),
    .rt_data(rt_data),
    .req    (req),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned edge_no;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb_q[$];

  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  // Reference model state: architectural HI/LO plus one outstanding result.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] p_hi;
  logic [31:0] p_lo;
  bit          p_wr;
  bit          pend = 1'b0;
  int unsigned done_edge;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pop every prediction whose edge has passed and compare it with the DUT.
  always @(negedge clk) begin
    exp_t r;
    while (sb_q.size() > 0 && sb_q[0].edge_no <= cyc) begin
      r = sb_q.pop_front();
      if (r.edge_no != cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_sample: got edge %0d expected edge %0d", cyc, r.edge_no);
      end else begin
        check32("busy", {31'd0, busy}, {31'd0, r.busy});
        check32("hi", hi, r.hi);
        check32("lo", lo, r.lo);
      end
    end
  end

  task automatic launch(input logic [31:0] rh, input logic [31:0] rl, input bit wr,
                        input int unsigned finish_edge);
    pend      = 1'b1;
    p_hi      = rh;
    p_lo      = rl;
    p_wr      = wr;
    done_edge = finish_edge;
  endtask

  // Architectural effect of an accepted op at edge e.
  task automatic model_accept(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              input int unsigned e);
    longint          sa64, sb64, sp;
    longint unsigned up;
    int              sa, sb, q, r;
    case (op)
      3'd1: begin
        sa64 = longint'($signed(a));
        sb64 = longint'($signed(b));
        sp   = sa64 * sb64;
        launch(sp[63:32], sp[31:0], 1'b1, e + MUL_N);
      end
      3'd2: begin
        up = longint'({32'd0, a}) * longint'({32'd0, b});
        launch(up[63:32], up[31:0], 1'b1, e + MUL_N);
      end
      3'd3: begin
        if (b == 32'd0) begin
          launch(32'd0, 32'd0, 1'b0, e + DIV_N);
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          launch(32'd0, 32'h8000_0000, 1'b1, e + DIV_N);
        end else begin
          sa = a;
          sb = b;
          q  = sa / sb;
          r  = sa % sb;
          launch(r, q, 1'b1, e + DIV_N);
        end
      end
      3'd4: begin
        if (b == 32'd0) launch(32'd0, 32'd0, 1'b0, e + DIV_N);
        else            launch(a % b, a / b, 1'b1, e + DIV_N);
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endtask

  // Drive one op for the next rising edge and queue the predicted state after it.
  task automatic step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic fl);
    int unsigned e;
    bit          was_busy;
    exp_t        r;
    mdu_op   = op;
    rs_data  = a;
    rt_data  = b;
    req      = fl;
    e        = cyc + 1;
    was_busy = pend;
    if (pend && e == done_edge) begin
      if (p_wr) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
      pend = 1'b0;
    end
    if (!was_busy && !fl) model_accept(op, a, b, e);
    r.edge_no = e;
    r.busy    = pend;
    r.hi      = m_hi;
    r.lo      = m_lo;
    sb_q.push_back(r);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(3'd0, 32'd0, 32'd0, 1'b0);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] specials [5];
    specials = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd7};
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    return $urandom();
  endfunction

  initial begin
    reset   = 1'b0;
    mdu_op  = 3'd0;
    rs_data = 32'd0;
    rt_data = 32'd0;
    req     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check32("reset_busy", {31'd0, busy}, 32'd0);
    check32("reset_hi", hi, 32'd0);
    check32("reset_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of a multiply: cleared at once, and the result never lands.
    step(3'd5, 32'h99, 32'd0, 1'b0);
    step(3'd6, 32'h77, 32'd0, 1'b0);
    step(3'd1, 32'd3, 32'd4, 1'b0);
    idle(2);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check32("midrun_reset_busy", {31'd0, busy}, 32'd0);
    check32("midrun_reset_hi", hi, 32'd0);
    check32("midrun_reset_lo", lo, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    pend = 1'b0;
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    idle(10);

    // Signed and unsigned multiply of the same operands.
    step(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    idle(MUL_N + 1);
    step(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
    idle(MUL_N + 1);

    // Signed divide: truncation, overflow case, and divide by zero leaving HI/LO.
    step(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle(DIV_N + 1);
    step(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(DIV_N + 1);
    step(3'd5, 32'h11, 32'd0, 1'b0);
    step(3'd6, 32'h22, 32'd0, 1'b0);
    step(3'd4, 32'd7, 32'd0, 1'b0);
    idle(DIV_N + 1);

    // Ops arriving during busy are dropped.
    step(3'd5, 32'd0, 32'd0, 1'b0);
    step(3'd6, 32'd0, 32'd0, 1'b0);
    step(3'd2, 32'd2, 32'd3, 1'b0);
    step(3'd6, 32'h55, 32'd0, 1'b0);
    step(3'd3, 32'd9, 32'd2, 1'b0);
    idle(MUL_N);

    // Flush blocks acceptance but not an operation already running.
    step(3'd5, 32'hABCD, 32'd0, 1'b1);
    step(3'd1, 32'd5, 32'd7, 1'b1);
    step(3'd0, 32'd0, 32'd0, 1'b0);
    step(3'd1, 32'hFFFF_FFFB, 32'd7, 1'b0);
    for (int i = 0; i < 3; i++) step(3'd5, 32'hDEAD, 32'd0, 1'b1);
    idle(4);

    // Back-to-back moves, then an op on the first idle edge after a completion.
    step(3'd5, 32'h1234, 32'd0, 1'b0);
    step(3'd6, 32'h5678, 32'd0, 1'b0);
    step(3'd1, 32'd100, 32'hFFFF_FFFF, 1'b0);
    idle(MUL_N);
    step(3'd4, 32'd100, 32'd7, 1'b0);
    idle(DIV_N);
    step(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    idle(MUL_N + 1);

    // Randomised traffic including reserved op, flushes and special operands.
    for (int i = 0; i < 400; i++) begin
      step(3'($urandom_range(0, 7)), rand_operand(), rand_operand(),
           ($urandom_range(0, 7) == 0));
    end
    idle(DIV_N + 2);

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the EX stage, alongside the ALU, downstream of the immediate extender/operand mux.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO against private HI/LO registers.
- Multi-cycle: raises busy so the hazard unit can stall later HI/LO consumers.
- Honours an exception/interrupt flush so squashed instructions never touch HI/LO.

Parameters:
- MUL_CYCLES, 5, busy duration in cycles for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, 10, busy duration in cycles for DIV/DIVU (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- mdu_op  input  3  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- rs_data  input  32  operand A (dividend/multiplicand); source for MTHI/MTLO.
- rt_data  input  32  operand B (divisor/multiplier).
- req  input  1  flush: the EX instruction is being cancelled by an exception/interrupt.
- busy  output  1  operation in flight.
- hi  output  32  current HI register.
- lo  output  32  current LO register.

Behaviour:
- Reset (reset==0, asynchronous): hi=0, lo=0, busy=0, state=IDLE, counter=0. A reset in RUN discards the pending result.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter decrements each cycle.
- Accept rule: an op is accepted on a rising edge only when state==IDLE and req==0. Any op presented while busy=1, or with req=1, is ignored entirely: no state change, no HI/LO write.
- Accepting op 1-4:
  - Compute the result from rs_data/rt_data sampled at that edge into internal pending_hi/pending_lo.
  - Enter RUN with counter = MUL_CYCLES-1 (ops 1, 2) or DIV_CYCLES-1 (ops 3, 4).
  - busy is high from the cycle after the accept edge for exactly MUL_CYCLES or DIV_CYCLES cycles.
- In RUN:
  - Each edge with counter!=0 decrements the counter.
  - The edge with counter==0 writes hi<=pending_hi and lo<=pending_lo and returns to IDLE, so busy falls in the same cycle the new HI/LO become visible.
- MTHI/MTLO: when accepted, hi<=rs_data or lo<=rs_data on that edge; latency 1, busy stays 0.
- Arithmetic:
  - MULT: 64-bit signed product, {hi,lo}=rs*rt.
  - MULTU: unsigned product.
  - DIV/DIVU: lo=quotient, hi=remainder.
  - Signed quotient truncates toward zero; the signed remainder takes the sign of the dividend.
- Special cases:
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (op 3 or 4 with rt_data==0): busy still runs DIV_CYCLES; hi/lo are left unchanged at completion.
- req does not abort an operation already in RUN; that instruction has already committed.
- hi/lo are plain register outputs with no combinational path from inputs.
- The hazard unit stalls MFHI/MFLO/MDU ops when busy=1 or when an op 1-4 is presented in EX. The unit itself never queues requests.

Test Plan:
- Reset mid-RUN: MULT 3*4, then drop reset two cycles later -> hi=0, lo=0, busy=0 immediately (asynchronous); after reset is released, no write ever lands.
- MULT 0xFFFFFFFE * 3 (signed) -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV signed cases:
  - -7/2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIVU 7/0 with hi=0x11, lo=0x22 beforehand -> still 0x11/0x22 after 10 busy cycles.
- Busy collision: MULTU 2*3, then MTLO 0x55 and DIV during busy -> both ignored; final lo=6, hi=0, busy duration unchanged at 5.
- Flush: MTHI 0xABCD with req=1 -> hi unchanged; MULT with req=1 -> busy stays 0. MULT accepted, then req=1 during RUN -> the result still lands.
- Back-to-back: MTHI 0x1234 then MTLO 0x5678 on consecutive cycles -> hi=0x1234 and lo=0x5678 one cycle after each, busy=0 throughout; an op accepted on the first IDLE cycle after a completion starts with no bubble.
